pipeline_scoreboard: RTL
========================

// Module: pipeline_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding scoreboard for the decode stage of the pipelined CPU.
//  Tracks in-flight register writes by age and result latency, so variable-latency units
//  (ALU=1, load=2, longer multi-cycle ops) share one stall/forward engine.
//  Outputs the load-use stall and a per-operand forward-source select (stages ahead, 0 = regfile).
//  Adds flush support, WAW handling and a stall-cycle performance counter.
// PARAMETERS
//  NREG       16  architectural registers; register 0 is hardwired zero, never tracked
//  DEPTH       3  stages between issue and write-back (age DEPTH = in write-back)
//  MAX_LAT     3  largest legal issue latency, 1..DEPTH
//  KILL_DEPTH  1  flush removes entries with age <= KILL_DEPTH (wrong-path ops)
//  CNT_W      16  stall_cycles counter width
//  derived: RW = clog2(NREG), AW = clog2(DEPTH+1)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      synchronous active-high reset
//  iss_valid     in   1      instruction presented at decode
//  iss_wen       in   1      instruction writes a register
//  iss_dst       in   RW     destination register
//  iss_lat       in   AW     cycles after issue until result is forwardable (1..MAX_LAT)
//  src1/src2     in   RW     source registers of the decode instruction
//  src1_used     in   1      src1 is read (same for src2_used/src2)
//  flush         in   1      branch taken: kill the young ops, block this issue
//  stall         out  1      hold decode/fetch, inject bubble into EX
//  fwd1/fwd2     out  AW     producer age for src1/src2; 0 = read register file
//  busy_vec      out  NREG   per-register pending-write flag (bit 0 always 0)
//  stall_cycles  out  CNT_W  saturating count of stalled issue cycles
// BEHAVIOUR
//  - Per-register entry {busy, age[AW], lat[AW]}; all registered; zero at reset.
//  - Outputs combinational from state + inputs; reset values: stall=0, fwd*=0, busy_vec=0,
//    stall_cycles=0.
//  - Operand hit: srcN_used & srcN!=0 & busy[srcN].
//    Hit & age<lat -> not ready -> stall=1. Hit & age>=lat -> fwdN=age, no stall. Else fwdN=0.
//  - stall = not-ready(src1) | not-ready(src2); independent of iss_valid. Forced 0 when flush=1.
//  - Accept = iss_valid & ~stall & ~flush & ~rst.
//  - Each edge (no rst): busy entries with age<DEPTH -> age+1; age==DEPTH -> busy=0 (retired).
//  - Flush edge: entries with age<=KILL_DEPTH cleared before ageing; older entries age normally.
//  - Accept with iss_wen & iss_dst!=0: entry[iss_dst] <= {1, 1, iss_lat}. Overrides ageing or
//    retirement of the same register that cycle (WAW: youngest producer wins).
//  - iss_dst==0 or iss_wen==0: no entry created.
//  - iss_lat outside 1..MAX_LAT is illegal. Assertion in sim; RTL clamps to MAX_LAT
//    (lat 0 treated as 1).
//  - stall_cycles += 1 when iss_valid & stall & ~flush; saturates at all-ones; no wrap.
//  - rst=1 at any time: all entries, counter cleared at that edge, issue ignored.
//    Outputs reflect the cleared state on the next cycle.
//  - Latency: producer accepted at edge N is visible (age 1) from cycle N+1.
//    Consumer readiness at cycle N+k needs k>=lat. Entry retires after the cycle at age DEPTH.
//    The register file must write-through, or the consumer reads the regfile next cycle.
// TESTING  (NREG=16, DEPTH=3, MAX_LAT=3, KILL_DEPTH=1)
//  1 ALU chain: accept r3 lat1 @c0. src1=r3 used in c1,c2,c3,c4 -> fwd1=1,2,3,0; stall=0 throughout;
//    busy_vec[3] 1 in c1..c3, 0 in c4.
//  2 Load-use: accept r5 lat2 @c0. c1 src2=r5 used, iss_valid -> stall=1, stall_cycles 0->1.
//    c2 -> stall=0, fwd2=2.
//  3 r0/unused: issue dst=r0 -> busy_vec=0. src1=r7 busy lat3 age1 with src1_used=0 -> stall=0, fwd1=0.
//  4 WAW: accept r2 lat3 @c0, accept r2 lat1 @c1. c2 src1=r2 -> age1, lat1, fwd1=1, stall=0.
//    busy_vec[2] clears after c4.
//  5 Flush: r4 accepted @c0, r9 (lat1) accepted @c-2. c1 flush=1, iss_valid dst r6 -> c2:
//    busy_vec[4]=0, [6]=0, [9]=0 (retired).
//  6 Reset/saturate: preload stall_cycles to 16'hFFFF via a held stall -> stays FFFF.
//    rst=1 mid-op -> next cycle busy_vec=0, stall_cycles=0, stall=0.

Source files
------------

// File: rtl/pipeline_scoreboard_if.sv
// Decode-stage issue/operand bus and the hazard scoreboard's stall/forward/status outputs.
// master = decode logic driving issue and sources; slave = the scoreboard itself.
interface pipeline_scoreboard_if #(
    parameter int NREG  = 16,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int RW = $clog2(NREG);
    localparam int AW = $clog2(DEPTH + 1);

    logic             iss_valid;
    logic             iss_wen;
    logic [RW-1:0]    iss_dst;
    logic [AW-1:0]    iss_lat;
    logic [RW-1:0]    src1;
    logic [RW-1:0]    src2;
    logic             src1_used;
    logic             src2_used;
    logic             flush;
    logic             stall;
    logic [AW-1:0]    fwd1;
    logic [AW-1:0]    fwd2;
    logic [NREG-1:0]  busy_vec;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output iss_valid, iss_wen, iss_dst, iss_lat,
        output src1, src2, src1_used, src2_used, flush,
        input  stall, fwd1, fwd2, busy_vec, stall_cycles
    );

    modport slave (
        input  iss_valid, iss_wen, iss_dst, iss_lat,
        input  src1, src2, src1_used, src2_used, flush,
        output stall, fwd1, fwd2, busy_vec, stall_cycles
    );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Decode hazard scoreboard: per-register in-flight write tracking, load-use stall, forward-age select.
// Latency: outputs combinational from state; issue visible at age 1 next cycle. Backpressure: stall holds decode.
module pipeline_scoreboard #(
    parameter int NREG       = 16,
    parameter int DEPTH      = 3,
    parameter int MAX_LAT    = 3,
    parameter int KILL_DEPTH = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_scoreboard_if.slave sb
);
    localparam int RW = $clog2(NREG);
    localparam int AW = $clog2(DEPTH + 1);

    logic [NREG-1:0]  busy_q;
    logic [AW-1:0]    age_q [NREG];
    logic [AW-1:0]    lat_q [NREG];
    logic [CNT_W-1:0] stall_cnt_q;

    logic          hit1, hit2, wait1, wait2;
    logic          accept;
    logic [AW-1:0] lat_in;

    // A hit whose producer has not reached its result latency cannot be forwarded yet.
    always_comb begin
        hit1  = sb.src1_used && (sb.src1 != '0) && busy_q[sb.src1];
        hit2  = sb.src2_used && (sb.src2 != '0) && busy_q[sb.src2];
        wait1 = hit1 && (age_q[sb.src1] < lat_q[sb.src1]);
        wait2 = hit2 && (age_q[sb.src2] < lat_q[sb.src2]);
    end

    assign sb.stall        = (wait1 || wait2) && !sb.flush;
    assign sb.fwd1         = (hit1 && !wait1) ? age_q[sb.src1] : '0;
    assign sb.fwd2         = (hit2 && !wait2) ? age_q[sb.src2] : '0;
    assign sb.busy_vec     = busy_q;
    assign sb.stall_cycles = stall_cnt_q;

    assign accept = sb.iss_valid && !sb.stall && !sb.flush && !rst;

    always_comb begin
        lat_in = sb.iss_lat;
        if (sb.iss_lat == '0)
            lat_in = AW'(1);
        else if (sb.iss_lat > AW'(MAX_LAT))
            lat_in = AW'(MAX_LAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                age_q[i] <= '0;
                lat_q[i] <= '0;
            end
        end else begin
            busy_q[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (busy_q[i]) begin
                    if ((sb.flush && (age_q[i] <= AW'(KILL_DEPTH))) || (age_q[i] == AW'(DEPTH))) begin
                        busy_q[i] <= 1'b0;
                        age_q[i]  <= '0;
                        lat_q[i]  <= '0;
                    end else begin
                        age_q[i] <= age_q[i] + AW'(1);
                    end
                end
                // Youngest producer overwrites whatever the older write was doing this cycle.
                if (accept && sb.iss_wen && (sb.iss_dst == RW'(i))) begin
                    busy_q[i] <= 1'b1;
                    age_q[i]  <= AW'(1);
                    lat_q[i]  <= lat_in;
                end
            end
            if (sb.iss_valid && sb.stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    lat_legal: assert property (@(posedge clk) disable iff (rst)
        (sb.iss_valid && sb.iss_wen && !sb.flush) |-> ((sb.iss_lat != '0) && (sb.iss_lat <= AW'(MAX_LAT))));
endmodule
